// File: rtl/dcache_wt_if.sv
// Core-side and memory-side signals of the write-through data cache.
// slave = cache view, master = core + data memory view.
interface dcache_wt_if #(
    parameter int CNT_W = 16
);
    logic             MemReadM;
    logic             MemWriteM;
    logic [31:0]      ALUResult;
    logic [31:0]      WriteData;
    logic [31:0]      ReadData;
    logic             StallM;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wd;
    logic [31:0]      mem_rd;
    logic             mem_ack;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport slave (
        input  MemReadM, MemWriteM, ALUResult, WriteData, mem_rd, mem_ack,
        output ReadData, StallM, mem_req, mem_we, mem_addr, mem_wd, hit_cnt, miss_cnt
    );

    modport master (
        output MemReadM, MemWriteM, ALUResult, WriteData, mem_rd, mem_ack,
        input  ReadData, StallM, mem_req, mem_we, mem_addr, mem_wd, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache, one word per line.
// state | meaning
// IDLE  | lookup; hits answer in the same cycle, misses/stores launch a memory request
// FILL  | load miss outstanding; line written from mem_rd on mem_ack
// WRITE | store outstanding; cached copy updated on mem_ack if the line is present
// WDONE | one unstalled cycle so the core retires the store without re-issuing it
module dcache_wt #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    dcache_wt_if.slave bus
);
    localparam int LINES = 2 ** IDX_BITS;
    localparam int TAG_W = 32 - IDX_BITS - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic               r_req;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [31:0]        r_wd;
    logic               r_refill;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_BITS-1:0] w_pidx;
    logic [TAG_W-1:0]    w_ptag;
    logic                w_hit;
    logic                w_pend_hit;
    logic                w_stall;
    logic                w_start_rd;
    logic                w_start_wr;
    logic                w_count_hit;

    assign w_idx      = bus.ALUResult[IDX_BITS+1:2];
    assign w_tag      = bus.ALUResult[31:IDX_BITS+2];
    assign w_pidx     = r_addr[IDX_BITS+1:2];
    assign w_ptag     = r_addr[31:IDX_BITS+2];
    assign w_hit      = bus.MemReadM & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_pend_hit = r_valid[w_pidx] & (r_tag[w_pidx] == w_ptag);
    // The load retried right after a fill is the same access that already counted as a miss.
    assign w_count_hit = (r_state == IDLE) & ~bus.MemWriteM & w_hit & ~r_refill;

    assign bus.ReadData = w_hit ? r_data[w_idx] : 32'h0;
    assign bus.StallM   = w_stall;
    assign bus.mem_req  = r_req;
    assign bus.mem_we   = r_we;
    assign bus.mem_addr = r_addr;
    assign bus.mem_wd   = r_wd;
    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state, stall and request-launch decode; stores win over loads.
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_start_rd = 1'b0;
        w_start_wr = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.MemWriteM) begin
                    w_stall    = 1'b1;
                    w_start_wr = 1'b1;
                    w_next     = WRITE;
                end else if (bus.MemReadM && !w_hit) begin
                    w_stall    = 1'b1;
                    w_start_rd = 1'b1;
                    w_next     = FILL;
                end
            end
            FILL: begin
                w_stall = 1'b1;
                if (bus.mem_ack) w_next = IDLE;
            end
            WRITE: begin
                w_stall = 1'b1;
                if (bus.mem_ack) w_next = WDONE;
            end
            WDONE:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Memory request registers and line array updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid  <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wd     <= 32'h0;
            r_refill <= 1'b0;
            for (int i = 0; i < LINES; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= 32'h0;
            end
        end else begin
            r_refill <= 1'b0;
            if (w_start_rd || w_start_wr) begin
                r_req  <= 1'b1;
                r_we   <= w_start_wr;
                r_addr <= {bus.ALUResult[31:2], 2'b00};
                if (w_start_wr) r_wd <= bus.WriteData;
            end
            if (r_state == FILL && bus.mem_ack) begin
                r_req          <= 1'b0;
                r_valid[w_pidx] <= 1'b1;
                r_tag[w_pidx]  <= w_ptag;
                r_data[w_pidx] <= bus.mem_rd;
                r_refill       <= 1'b1;
            end
            if (r_state == WRITE && bus.mem_ack) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                if (w_pend_hit) r_data[w_pidx] <= r_wd;
            end
        end
    end

    // Saturating load hit/miss counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_count_hit && r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            if (w_start_rd && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Self-checking bench for dcache_wt: directed scenarios plus random traffic
// against a line-level cache/memory model.
module tb_dcache_wt;
    localparam int CNT_W   = 4;
    localparam int IDX     = 4;
    localparam int LINES   = 2 ** IDX;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dcache_wt_if #(.CNT_W(CNT_W)) bus ();
    dcache_wt #(.IDX_BITS(IDX), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory environment.
    logic [31:0] phys_mem [logic [29:0]];
    bit          mem_auto;
    int          mem_lat;
    logic        manual_ack;
    logic [31:0] manual_rd;
    int          req_count;
    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wd;

    // Reference model.
    bit          m_valid [LINES];
    logic [25:0] m_tag   [LINES];
    logic [31:0] m_data  [LINES];
    logic [31:0] m_mem   [logic [29:0]];
    int          exp_hits;
    int          exp_misses;

    function automatic logic [31:0] defval(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] phys_read(input logic [31:0] a);
        if (phys_mem.exists(a[31:2])) return phys_mem[a[31:2]];
        return defval(a);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (m_mem.exists(a[31:2])) return m_mem[a[31:2]];
        return defval(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    // Responds to each request after mem_lat cycles of mem_req, or replays manual_ack.
    initial begin
        int age;
        age = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rd  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                bus.mem_ack = manual_ack;
                bus.mem_rd  = manual_rd;
                age = 0;
            end else begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req === 1'b1) begin
                    if (age == 0) begin
                        req_count++;
                        last_we   = bus.mem_we;
                        last_addr = bus.mem_addr;
                        last_wd   = bus.mem_wd;
                    end
                    age++;
                    if (age > mem_lat) begin
                        bus.mem_ack = 1'b1;
                        if (last_we) phys_mem[last_addr[31:2]] = last_wd;
                        else         bus.mem_rd = phys_read(last_addr);
                        age = 0;
                    end
                end else begin
                    age = 0;
                end
            end
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        phys_mem[a[31:2]] = d;
        m_mem[a[31:2]]    = d;
    endtask

    // One core access; called at posedge+1, returns at posedge+1 after an idle cycle.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat);
        int          idx;
        logic [25:0] tag;
        bit          is_load;
        bit          m_hit;
        bit          goes_mem;
        int          exp_stall;
        logic [31:0] exp_rd;
        int          stalls;
        bit          done;
        logic [31:0] rdata;
        int          reqs0;

        idx       = int'(addr[5:2]);
        tag       = addr[31:6];
        is_load   = rd && !wr;
        m_hit     = is_load && m_valid[idx] && (m_tag[idx] == tag);
        goes_mem  = wr || (is_load && !m_hit);
        exp_stall = goes_mem ? 2 + lat : 0;
        mem_lat   = lat;
        reqs0     = req_count;

        bus.MemReadM  = rd;
        bus.MemWriteM = wr;
        bus.ALUResult = addr;
        bus.WriteData = wd;
        stalls = 0;
        done   = 1'b0;
        rdata  = 32'h0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (bus.StallM === 1'b0) begin
                done  = 1'b1;
                rdata = bus.ReadData;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        bus.MemReadM  = 1'b0;
        bus.MemWriteM = 1'b0;

        if (wr) begin
            m_mem[addr[31:2]] = wd;
            if (m_valid[idx] && m_tag[idx] == tag) m_data[idx] = wd;
        end else if (is_load) begin
            if (m_hit) begin
                exp_rd = m_data[idx];
                if (exp_hits < CNT_MAX) exp_hits++;
            end else begin
                exp_rd       = model_read(addr);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = tag;
                m_data[idx]  = exp_rd;
                if (exp_misses < CNT_MAX) exp_misses++;
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL access_timeout addr=%h: StallM never released", addr);
        end else if (stalls != exp_stall) begin
            errors++;
            $display("FAIL stall_cycles addr=%h rd=%0d wr=%0d: got %0d expected %0d",
                     addr, rd, wr, stalls, exp_stall);
        end
        if (is_load) begin
            checks++;
            if (rdata !== exp_rd) begin
                errors++;
                $display("FAIL read_data addr=%h: got %h expected %h", addr, rdata, exp_rd);
            end
        end
        checks++;
        if (req_count != reqs0 + (goes_mem ? 1 : 0)) begin
            errors++;
            $display("FAIL mem_req_count addr=%h: got %0d expected %0d",
                     addr, req_count - reqs0, goes_mem ? 1 : 0);
        end else if (goes_mem) begin
            checks++;
            if (last_we !== wr || last_addr !== {addr[31:2], 2'b00} || (wr && last_wd !== wd)) begin
                errors++;
                $display("FAIL mem_fields addr=%h: we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h",
                         addr, last_we, last_addr, last_wd, wr, {addr[31:2], 2'b00}, wd);
            end
        end
        checks++;
        if (bus.hit_cnt !== CNT_W'(exp_hits) || bus.miss_cnt !== CNT_W'(exp_misses)) begin
            errors++;
            $display("FAIL counters addr=%h: hit=%0d miss=%0d expected hit=%0d miss=%0d",
                     addr, bus.hit_cnt, bus.miss_cnt, exp_hits, exp_misses);
        end
        @(negedge clk);
        checks++;
        if (bus.StallM !== 1'b0 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL idle_after addr=%h: StallM=%b mem_req=%b expected 0 0",
                     addr, bus.StallM, bus.mem_req);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.MemReadM  = 1'b1;
        bus.ALUResult = 32'h40;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 ||
            bus.mem_wd !== 32'h0 || bus.ReadData !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h rdata=%h expected all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wd, bus.ReadData);
        end
        checks++;
        if (bus.hit_cnt !== '0 || bus.miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counters: hit=%0d miss=%0d expected 0 0", bus.hit_cnt, bus.miss_cnt);
        end
        bus.MemReadM = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_load_miss_hit();
        preload(32'h40, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h40, 32'h0, 3);
        checks++;
        if (bus.miss_cnt !== 4'd1 || bus.hit_cnt !== 4'd0) begin
            errors++;
            $display("FAIL first_miss_counts: hit=%0d miss=%0d expected 0 1", bus.hit_cnt, bus.miss_cnt);
        end
        access(1'b1, 1'b0, 32'h40, 32'h0, 3);
        checks++;
        if (bus.hit_cnt !== 4'd1) begin
            errors++;
            $display("FAIL first_hit_count: hit=%0d expected 1", bus.hit_cnt);
        end
    endtask

    task automatic test_conflict();
        access(1'b1, 1'b0, 32'h80, 32'h0, 1);
        access(1'b1, 1'b0, 32'h40, 32'h0, 2);
        checks++;
        if (bus.miss_cnt !== 4'd3) begin
            errors++;
            $display("FAIL conflict_miss_count: miss=%0d expected 3", bus.miss_cnt);
        end
    endtask

    task automatic test_store();
        access(1'b0, 1'b1, 32'h40, 32'h1234, 2);
        access(1'b1, 1'b0, 32'h40, 32'h0, 1);
        access(1'b0, 1'b1, 32'hC4, 32'hCAFE_0001, 0);
        access(1'b1, 1'b0, 32'hC4, 32'h0, 1);
        access(1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 1);
        access(1'b1, 1'b0, 32'h40, 32'h0, 0);
    endtask

    task automatic test_reset_fill();
        mem_auto   = 1'b0;
        manual_ack = 1'b0;
        manual_rd  = 32'h0;
        bus.MemReadM  = 1'b1;
        bus.ALUResult = 32'h300;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1 || bus.StallM !== 1'b1) begin
            errors++;
            $display("FAIL fill_pending: mem_req=%b StallM=%b expected 1 1", bus.mem_req, bus.StallM);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_abandon: mem_req=%b mem_we=%b expected 0 0", bus.mem_req, bus.mem_we);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.MemReadM = 1'b0;
        model_reset();
        @(negedge clk);
        manual_ack = 1'b1;
        manual_rd  = 32'hBAD0_BAD0;
        @(negedge clk);
        manual_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0 || bus.StallM !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack: mem_req=%b StallM=%b expected 0 0", bus.mem_req, bus.StallM);
        end
        @(posedge clk);
        #1;
        mem_auto = 1'b1;
        access(1'b1, 1'b0, 32'h300, 32'h0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            int          op;
            a  = {24'h0, 2'(($urandom_range(0, 3))), 4'($urandom), 2'($urandom)};
            op = $urandom_range(0, 99);
            if (op < 60)      access(1'b1, 1'b0, a, 32'h0, $urandom_range(0, 3));
            else if (op < 88) access(1'b0, 1'b1, a, $urandom, $urandom_range(0, 3));
            else if (op < 94) access(1'b1, 1'b1, a, $urandom, $urandom_range(0, 3));
            else              access(1'b0, 1'b0, a, 32'h0, 0);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        access(1'b1, 1'b0, 32'h10, 32'h0, 0);
        for (int n = 0; n < (1 << CNT_W) + 1; n++) access(1'b1, 1'b0, 32'h10, 32'h0, 0);
        checks++;
        if (bus.hit_cnt !== 4'hF || bus.miss_cnt !== 4'd1) begin
            errors++;
            $display("FAIL hit_saturation: hit=%h miss=%h expected F 1", bus.hit_cnt, bus.miss_cnt);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        req_count     = 0;
        mem_auto      = 1'b1;
        mem_lat       = 0;
        manual_ack    = 1'b0;
        manual_rd     = 32'h0;
        last_we       = 1'b0;
        last_addr     = 32'h0;
        last_wd       = 32'h0;
        reset         = 1'b1;
        bus.MemReadM  = 1'b0;
        bus.MemWriteM = 1'b0;
        bus.ALUResult = 32'h0;
        bus.WriteData = 32'h0;
        model_reset();
        test_reset();
        test_load_miss_hit();
        test_conflict();
        test_store();
        test_reset_fill();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the pipelined core's memory stage and a multi-cycle data memory.
- Read hits return data in the same cycle.
- Misses and all stores hold the pipeline via StallM while a request/acknowledge transaction runs on the memory side.
- Replaces the direct core-to-dmem connection so data memory can take one or more cycles per access.

Parameters:
- IDX_BITS, 4, index width; lines = 2**IDX_BITS, one 32-bit word per line
- CNT_W, 16, width of the hit and miss counters

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- MemReadM  in  1  core load request in memory stage
- MemWriteM  in  1  core store request in memory stage
- ALUResult  in  32  byte address from core; [1:0] ignored
- WriteData  in  32  store data from core
- ReadData  out  32  load data to core
- StallM  out  1  hold core pipeline while high
- mem_req  out  1  memory transaction request, registered
- mem_we  out  1  1 = write transaction, registered
- mem_addr  out  32  word-aligned address, registered
- mem_wd  out  32  write data, registered
- mem_rd  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion pulse
- hit_cnt  out  CNT_W  load hits, saturating
- miss_cnt  out  CNT_W  load misses, saturating

Behaviour:
- Address split: index = ALUResult[IDX_BITS+1:2]; tag = ALUResult[31:IDX_BITS+2].
- Each line holds valid, tag and data.
- hit = MemReadM & valid[index] & tag match.
- Reset clears:
  - all valid bits;
  - state to IDLE;
  - mem_req, mem_we, mem_addr, mem_wd to 0;
  - both counters to 0.
- Reset value of ReadData = 0 (no valid lines). Reset mid-transaction abandons it; mem_ack arriving afterwards is ignored.
- ReadData = line data when hit, else 0 (combinational).
- States:
  - IDLE:
    - load hit: StallM = 0, data same cycle, hit_cnt += 1.
    - load miss: StallM = 1 combinationally; next edge goes to FILL with mem_req = 1, mem_we = 0, mem_addr = {ALUResult[31:2], 2'b00}; miss_cnt += 1 once.
    - store: StallM = 1; next edge goes to WRITE with mem_req = 1, mem_we = 1, mem_addr as above, mem_wd = WriteData.
    - MemReadM and MemWriteM both high: store takes priority; the load is ignored.
    - neither request: StallM = 0.
  - FILL:
    - StallM = 1; mem_req held until mem_ack.
    - On the mem_ack edge: write the line (valid = 1, tag, data = mem_rd), drop mem_req, return to IDLE.
    - The retried load then hits; that lookup is not counted as a hit.
  - WRITE:
    - StallM = 1; mem_req held until mem_ack.
    - On the mem_ack edge: if the line is valid and the tag matches, update its data to mem_wd; a miss does not allocate. Drop mem_req and mem_we, go to WDONE.
  - WDONE:
    - Exactly one cycle with StallM = 0 so the core advances past the store; the store is not re-issued.
    - Next state IDLE. A new request present in this cycle is evaluated in the following IDLE cycle.
- mem_ack outside FILL or WRITE is ignored.
- Core inputs are stable while StallM = 1; the design does not rely on them after leaving IDLE (registered copies are used).
- Load-miss penalty = 2 + (cycles from mem_req to mem_ack).
- Counters saturate at all-ones and do not wrap.

Test Plan:
- Reset, then load addr 0x40 with memory ack after 3 cycles and mem_rd = 0xDEADBEEF → StallM high 5 cycles, then ReadData = 0xDEADBEEF with StallM = 0; miss_cnt = 1, hit_cnt = 0. Second load of 0x40 → same-cycle hit, hit_cnt = 1.
- Load 0x40 then 0x80 (same index, IDX_BITS = 4, different tag) → second access misses and refills. A following load of 0x40 misses again; miss_cnt = 3.
- Store 0x1234 to cached 0x40 → mem_req/mem_we asserted with mem_addr = 0x40, mem_wd = 0x1234; StallM low exactly one cycle in WDONE. Load 0x40 → hit returning 0x1234.
- Store to uncached 0xC4 → memory written; a following load of 0xC4 misses, confirming no allocation.
- Assert reset during FILL, then pulse mem_ack → no line written, mem_req = 0, state IDLE, load of the same address misses.
- Force hit_cnt to all-ones via 2**CNT_W hits (CNT_W = 4 for this test) → hit_cnt stays 0xF.
